// File: rtl/cpu_control_fsm.sv
// Moore fetch/decode/execute sequencer for the 8-bit accumulator CPU datapath.
// Optional macro CPU_ILLEGAL_TRAP_EN: illegal opcodes enter a HALT state left only by reset.
module cpu_control_fsm #(
    parameter int OPCODE_W  = 8,
    parameter int ALU_SEL_W = 3,
    parameter int CCR_W     = 4,
    parameter int STATE_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  IR,
    input  logic [CCR_W-1:0]     CCR,
    output logic                 IR_LOAD,
    output logic                 CCR_LOAD,
    output logic                 MAR_LOAD,
    output logic                 PC_LOAD,
    output logic                 PC_INC,
    output logic                 A_LOAD,
    output logic                 B_LOAD,
    output logic [ALU_SEL_W-1:0] ALU_SEL,
    output logic [1:0]           TO_MEMORY_BUS_SEL,
    output logic [1:0]           FROM_MEMORY_BUS_SEL,
    output logic                 write,
    output logic                 instr_done,
    output logic                 halt,
    output logic [STATE_W-1:0]   dbg_state
);

    localparam logic [OPCODE_W-1:0] OP_LDA_IMM   = OPCODE_W'(8'h10);
    localparam logic [OPCODE_W-1:0] OP_LDA_DIR   = OPCODE_W'(8'h11);
    localparam logic [OPCODE_W-1:0] OP_LDB_IMM   = OPCODE_W'(8'h12);
    localparam logic [OPCODE_W-1:0] OP_LDB_DIR   = OPCODE_W'(8'h13);
    localparam logic [OPCODE_W-1:0] OP_STA_DIR   = OPCODE_W'(8'h14);
    localparam logic [OPCODE_W-1:0] OP_STB_DIR   = OPCODE_W'(8'h15);
    localparam logic [OPCODE_W-1:0] OP_ALU_FIRST = OPCODE_W'(8'h20);
    localparam logic [OPCODE_W-1:0] OP_ALU_LAST  = OPCODE_W'(8'h27);
    localparam logic [OPCODE_W-1:0] OP_BR_FIRST  = OPCODE_W'(8'h30);
    localparam logic [OPCODE_W-1:0] OP_BR_LAST   = OPCODE_W'(8'h38);

    // ALU states occupy the top eight codes so the low three bits are the ALU operation.
    typedef enum logic [STATE_W-1:0] {
        FETCH_0 = STATE_W'(0),  FETCH_1 = STATE_W'(1),  FETCH_2 = STATE_W'(2),
        DECODE  = STATE_W'(3),
        IMM_0   = STATE_W'(4),  IMM_1   = STATE_W'(5),  IMM_2A  = STATE_W'(6),
        IMM_2B  = STATE_W'(7),
        DIR_0   = STATE_W'(8),  DIR_1   = STATE_W'(9),  DIR_2   = STATE_W'(10),
        DIR_3   = STATE_W'(11), DIR_4A  = STATE_W'(12), DIR_4B  = STATE_W'(13),
        ST_0    = STATE_W'(14), ST_1    = STATE_W'(15), ST_2    = STATE_W'(16),
        ST_3A   = STATE_W'(17), ST_3B   = STATE_W'(18),
        BR_0    = STATE_W'(19), BR_1    = STATE_W'(20), BR_2    = STATE_W'(21),
        BR_SKIP = STATE_W'(22), HALT    = STATE_W'(23),
        ALU_0   = STATE_W'(24), ALU_1   = STATE_W'(25), ALU_2   = STATE_W'(26),
        ALU_3   = STATE_W'(27), ALU_4   = STATE_W'(28), ALU_5   = STATE_W'(29),
        ALU_6   = STATE_W'(30), ALU_7   = STATE_W'(31)
    } state_e;

    typedef struct packed {
        logic       ir_load;
        logic       ccr_load;
        logic       mar_load;
        logic       pc_load;
        logic       pc_inc;
        logic       a_load;
        logic       b_load;
        logic [2:0] alu_sel;
        logic [1:0] to_sel;
        logic [1:0] from_sel;
        logic       write;
        logic       instr_done;
        logic       halt;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctrl, ctrl_gated;
    logic   branch_taken;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state_q <= FETCH_0;
        else        state_q <= state_d;
    end

    // Flags [3]=N [2]=Z [1]=V [0]=C; only meaningful while IR holds a branch opcode.
    always_comb begin
        branch_taken = 1'b0;
        case (IR[3:0])
            4'd0:    branch_taken = 1'b1;
            4'd1:    branch_taken = CCR[3];
            4'd2:    branch_taken = !CCR[3];
            4'd3:    branch_taken = CCR[2];
            4'd4:    branch_taken = !CCR[2];
            4'd5:    branch_taken = CCR[1];
            4'd6:    branch_taken = !CCR[1];
            4'd7:    branch_taken = CCR[0];
            4'd8:    branch_taken = !CCR[0];
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = FETCH_0;
        case (state_q)
            FETCH_0: state_d = FETCH_1;
            FETCH_1: state_d = FETCH_2;
            FETCH_2: state_d = DECODE;
            DECODE: begin
                if (IR == OP_LDA_IMM || IR == OP_LDB_IMM)
                    state_d = IMM_0;
                else if (IR == OP_LDA_DIR || IR == OP_LDB_DIR)
                    state_d = DIR_0;
                else if (IR == OP_STA_DIR || IR == OP_STB_DIR)
                    state_d = ST_0;
                else if (IR >= OP_ALU_FIRST && IR <= OP_ALU_LAST)
                    state_d = state_e'(STATE_W'(ALU_0) | STATE_W'(IR[2:0]));
                else if (IR >= OP_BR_FIRST && IR <= OP_BR_LAST)
                    state_d = branch_taken ? BR_0 : BR_SKIP;
                else
`ifdef CPU_ILLEGAL_TRAP_EN
                    state_d = HALT;
`else
                    state_d = FETCH_0;
`endif
            end
            IMM_0:   state_d = IMM_1;
            IMM_1:   state_d = IR[1] ? IMM_2B : IMM_2A;
            DIR_0:   state_d = DIR_1;
            DIR_1:   state_d = DIR_2;
            DIR_2:   state_d = DIR_3;
            DIR_3:   state_d = IR[1] ? DIR_4B : DIR_4A;
            ST_0:    state_d = ST_1;
            ST_1:    state_d = ST_2;
            ST_2:    state_d = IR[0] ? ST_3B : ST_3A;
            BR_0:    state_d = BR_1;
            BR_1:    state_d = BR_2;
`ifdef CPU_ILLEGAL_TRAP_EN
            HALT:    state_d = HALT;
`endif
            default: state_d = FETCH_0;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            FETCH_0, IMM_0, DIR_0, ST_0, BR_0: begin
                ctrl.mar_load = 1'b1;
                ctrl.from_sel = 2'b01;
            end
            FETCH_1, IMM_1, DIR_1, ST_1: ctrl.pc_inc = 1'b1;
            FETCH_2: begin
                ctrl.ir_load  = 1'b1;
                ctrl.from_sel = 2'b10;
            end
            DIR_2, ST_2: begin
                ctrl.mar_load = 1'b1;
                ctrl.from_sel = 2'b10;
            end
            IMM_2A, DIR_4A, IMM_2B, DIR_4B: begin
                ctrl.a_load     = (state_q == IMM_2A) || (state_q == DIR_4A);
                ctrl.b_load     = (state_q == IMM_2B) || (state_q == DIR_4B);
                ctrl.from_sel   = 2'b10;
                ctrl.instr_done = 1'b1;
            end
            ST_3A, ST_3B: begin
                ctrl.write      = 1'b1;
                ctrl.to_sel     = (state_q == ST_3B) ? 2'b10 : 2'b01;
                ctrl.instr_done = 1'b1;
            end
            BR_2: begin
                ctrl.pc_load    = 1'b1;
                ctrl.from_sel   = 2'b10;
                ctrl.instr_done = 1'b1;
            end
            BR_SKIP: begin
                ctrl.pc_inc     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ALU_0, ALU_1, ALU_2, ALU_3, ALU_4, ALU_5, ALU_6, ALU_7: begin
                ctrl.alu_sel    = state_q[2:0];
                ctrl.ccr_load   = 1'b1;
                ctrl.b_load     = (state_q == ALU_5) || (state_q == ALU_7);
                ctrl.a_load     = !((state_q == ALU_5) || (state_q == ALU_7));
                ctrl.instr_done = 1'b1;
            end
`ifdef CPU_ILLEGAL_TRAP_EN
            HALT: ctrl.halt = 1'b1;
`endif
            default: ctrl = '0;
        endcase
    end

    // Reset gates the decoded outputs so a store in flight loses write the moment reset falls.
    assign ctrl_gated = reset ? ctrl : '0;
    assign dbg_state  = reset ? state_q : '0;

    assign IR_LOAD             = ctrl_gated.ir_load;
    assign CCR_LOAD            = ctrl_gated.ccr_load;
    assign MAR_LOAD            = ctrl_gated.mar_load;
    assign PC_LOAD             = ctrl_gated.pc_load;
    assign PC_INC              = ctrl_gated.pc_inc;
    assign A_LOAD              = ctrl_gated.a_load;
    assign B_LOAD              = ctrl_gated.b_load;
    assign ALU_SEL             = ALU_SEL_W'(ctrl_gated.alu_sel);
    assign TO_MEMORY_BUS_SEL   = ctrl_gated.to_sel;
    assign FROM_MEMORY_BUS_SEL = ctrl_gated.from_sel;
    assign write               = ctrl_gated.write;
    assign instr_done          = ctrl_gated.instr_done;
    assign halt                = ctrl_gated.halt;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: an instruction-level model predicts every cycle's outputs.
module tb_cpu_control_fsm;

    typedef struct packed {
        logic       ir_load;
        logic       ccr_load;
        logic       mar_load;
        logic       pc_load;
        logic       pc_inc;
        logic       a_load;
        logic       b_load;
        logic [2:0] alu_sel;
        logic [1:0] to_sel;
        logic [1:0] from_sel;
        logic       write;
        logic       done;
        logic       halt;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic [7:0] op;
        int         k;
    } exp_t;

    typedef enum {C_IMM, C_DIR, C_ST, C_ALU, C_BR, C_ILL} class_e;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IR;
    logic [3:0] CCR;
    logic       IR_LOAD, CCR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD;
    logic [2:0] ALU_SEL;
    logic [1:0] TO_MEMORY_BUS_SEL, FROM_MEMORY_BUS_SEL;
    logic       write, instr_done, halt;
    logic [4:0] dbg_state;
    vec_t       dut_vec;

    int n_checks = 0;
    int n_pass   = 0;
    int last_mar_cnt;
    int last_write_at;
    exp_t exp_q[$];

    cpu_control_fsm dut (
        .clk(clk), .reset(reset), .IR(IR), .CCR(CCR),
        .IR_LOAD(IR_LOAD), .CCR_LOAD(CCR_LOAD), .MAR_LOAD(MAR_LOAD), .PC_LOAD(PC_LOAD),
        .PC_INC(PC_INC), .A_LOAD(A_LOAD), .B_LOAD(B_LOAD), .ALU_SEL(ALU_SEL),
        .TO_MEMORY_BUS_SEL(TO_MEMORY_BUS_SEL), .FROM_MEMORY_BUS_SEL(FROM_MEMORY_BUS_SEL),
        .write(write), .instr_done(instr_done), .halt(halt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign dut_vec = '{ir_load: IR_LOAD, ccr_load: CCR_LOAD, mar_load: MAR_LOAD,
                       pc_load: PC_LOAD, pc_inc: PC_INC, a_load: A_LOAD, b_load: B_LOAD,
                       alu_sel: ALU_SEL, to_sel: TO_MEMORY_BUS_SEL,
                       from_sel: FROM_MEMORY_BUS_SEL, write: write, done: instr_done,
                       halt: halt};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic class_e op_class(input logic [7:0] op);
        if (op == 8'h10 || op == 8'h12) return C_IMM;
        if (op == 8'h11 || op == 8'h13) return C_DIR;
        if (op == 8'h14 || op == 8'h15) return C_ST;
        if (op >= 8'h20 && op <= 8'h27) return C_ALU;
        if (op >= 8'h30 && op <= 8'h38) return C_BR;
        return C_ILL;
    endfunction

    function automatic bit br_taken(input logic [7:0] op, input logic [3:0] f);
        case (op)
            8'h30: return 1'b1;
            8'h31: return f[3];
            8'h32: return !f[3];
            8'h33: return f[2];
            8'h34: return !f[2];
            8'h35: return f[1];
            8'h36: return !f[1];
            8'h37: return f[0];
            8'h38: return !f[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic int n_cycles(input logic [7:0] op, input bit tk);
        case (op_class(op))
            C_IMM:   return 7;
            C_DIR:   return 9;
            C_ST:    return 8;
            C_ALU:   return 5;
            C_BR:    return tk ? 7 : 5;
            default: return 4;
        endcase
    endfunction

    // Expected outputs in cycle k (1-based, fetch included) of instruction op.
    function automatic vec_t exp_at(input logic [7:0] op, input bit tk, input int k);
        vec_t v = '0;
        bit   to_b = (op == 8'h12) || (op == 8'h13) || (op == 8'h15);
        if (k == 1 || (k == 5 && op_class(op) inside {C_IMM, C_DIR, C_ST})
                   || (k == 5 && op_class(op) == C_BR && tk)) begin
            v.mar_load = 1'b1; v.from_sel = 2'b01;
        end else if (k == 2 || (k == 6 && op_class(op) inside {C_IMM, C_DIR, C_ST})) begin
            v.pc_inc = 1'b1;
        end else if (k == 3) begin
            v.ir_load = 1'b1; v.from_sel = 2'b10;
        end else if (k >= 5) begin
            case (op_class(op))
                C_IMM: begin v.a_load = !to_b; v.b_load = to_b; v.from_sel = 2'b10; v.done = 1'b1; end
                C_DIR: begin
                    if (k == 7) begin v.mar_load = 1'b1; v.from_sel = 2'b10; end
                    if (k == 9) begin v.a_load = !to_b; v.b_load = to_b; v.from_sel = 2'b10; v.done = 1'b1; end
                end
                C_ST: begin
                    if (k == 7) begin v.mar_load = 1'b1; v.from_sel = 2'b10; end
                    if (k == 8) begin v.write = 1'b1; v.to_sel = to_b ? 2'b10 : 2'b01; v.done = 1'b1; end
                end
                C_ALU: begin
                    v.alu_sel = op[2:0]; v.ccr_load = 1'b1; v.done = 1'b1;
                    v.b_load = (op == 8'h25 || op == 8'h27);
                    v.a_load = !(op == 8'h25 || op == 8'h27);
                end
                C_BR: begin
                    if (!tk) begin v.pc_inc = 1'b1; v.done = 1'b1; end
                    else if (k == 7) begin v.pc_load = 1'b1; v.from_sel = 2'b10; v.done = 1'b1; end
                end
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    always @(negedge clk) begin : compare
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("op%02h_cycle%0d", e.op, e.k), 32'(dut_vec), 32'(e.v));
        end
    end

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            #1;
            exp_q.push_back('{v: '0, op: 8'h00, k: 0});
            check("reset_dbg_state", 32'(dbg_state), 32'd0);
        end
    endtask

    // Runs one instruction; exp_len is the hand-derived cycle of instr_done (0 = none).
    task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr,
                             input logic [3:0] ccr_late, input int exp_len, input int abort_at);
        bit tk      = br_taken(op, ccr);
        int n       = n_cycles(op, tk);
        int done_at = 0;
        last_mar_cnt  = 0;
        last_write_at = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin reset = 1'b1; IR = op; CCR = ccr; end
            if (k == 5) CCR = ccr_late;
            #1;
            exp_q.push_back('{v: exp_at(op, tk, k), op: op, k: k});
            if (instr_done && done_at == 0) done_at = k;
            if (MAR_LOAD) last_mar_cnt++;
            if (write) last_write_at = k;
            if (k == abort_at) begin
                @(negedge clk); #2;
                reset = 1'b0;
                #1;
                check("abort_write", 32'(write), 32'd0);
                check("abort_outputs", 32'(dut_vec), 32'd0);
                return;
            end
        end
        check($sformatf("op%02h_done_cycle", op), 32'(done_at), 32'(exp_len));
    endtask

    initial begin
        reset = 1'b0;
        IR    = 8'h00;
        CCR   = 4'h0;
        reset_cycles(3);
        run_instr(8'h10, 4'h0, 4'h0, 7, 0);
        run_instr(8'h15, 4'h0, 4'h0, 8, 0);
        check("stb_write_cycle", 32'(last_write_at), 32'd8);
        check("stb_mar_pulses", 32'(last_mar_cnt), 32'd3);
        run_instr(8'h25, 4'h0, 4'h0, 5, 0);
        run_instr(8'h21, 4'h0, 4'h0, 5, 0);
        run_instr(8'h33, 4'b0100, 4'b0000, 7, 0);
        run_instr(8'h33, 4'b0000, 4'b0100, 5, 0);
        run_instr(8'h11, 4'h0, 4'h0, 9, 0);
        run_instr(8'h13, 4'h0, 4'h0, 9, 0);
        run_instr(8'h12, 4'h0, 4'h0, 7, 0);
        run_instr(8'h14, 4'h0, 4'h0, 8, 0);
        check("sta_write_cycle", 32'(last_write_at), 32'd8);
        for (int op = 8'h20; op <= 8'h27; op++)
            run_instr(8'(op), 4'h0, 4'hF, 5, 0);
        for (int op = 8'h30; op <= 8'h38; op++) begin
            run_instr(8'(op), 4'hF, 4'h0, br_taken(8'(op), 4'hF) ? 7 : 5, 0);
            run_instr(8'(op), 4'h0, 4'hF, br_taken(8'(op), 4'h0) ? 7 : 5, 0);
        end
`ifdef CPU_ILLEGAL_TRAP_EN
        begin
            logic [4:0] halt_state;
            run_instr(8'hFF, 4'h0, 4'h0, 0, 0);
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #2;
                exp_q.push_back('{v: '{halt: 1'b1, default: '0}, op: 8'hFF, k: 5 + i});
                if (i == 0) halt_state = dbg_state;
                else check("halt_state_stable", 32'(dbg_state), 32'(halt_state));
            end
            reset_cycles(2);
        end
`else
        run_instr(8'h16, 4'h0, 4'h0, 0, 0);
        run_instr(8'h28, 4'h0, 4'h0, 0, 0);
        run_instr(8'h39, 4'h0, 4'h0, 0, 0);
        run_instr(8'h00, 4'h0, 4'h0, 0, 0);
        run_instr(8'hFF, 4'h0, 4'h0, 0, 0);
`endif
        run_instr(8'h10, 4'h0, 4'h0, 7, 0);
        run_instr(8'h14, 4'h0, 4'h0, 8, 8);
        reset_cycles(2);
        run_instr(8'h20, 4'h0, 4'h0, 5, 0);
        @(negedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Parametrised Moore control sequencer for the 8-bit accumulator CPU. It implements the full instruction set (immediate/direct loads, direct stores, ALU ops, conditional branches) as a multi-cycle fetch/decode/execute FSM. It drives load strobes, bus selects, ALU select and memory write for the PC/MAR/IR/A/B/CCR datapath. There is no instruction pipelining.

Parameters:
OPCODE_W, 8, width of IR and opcode constants
ALU_SEL_W, 3, width of ALU_SEL; must be >= 3
CCR_W, 4, width of CCR; bit order fixed at [3]=N [2]=Z [1]=V [0]=C; extra upper bits ignored
STATE_W, 5, width of the state register and the dbg_state port

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
IR  in  OPCODE_W  current opcode
CCR  in  CCR_W  condition flags
IR_LOAD, CCR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD  out  1 each  datapath strobes
ALU_SEL  out  ALU_SEL_W  ALU operation
TO_MEMORY_BUS_SEL  out  2  00=PC 01=A 10=B
FROM_MEMORY_BUS_SEL  out  2  00=ALU result 01=TO_MEMORY_BUS 10=memory data
write  out  1  memory write enable
instr_done  out  1  1-cycle pulse in the last execute cycle
halt  out  1  illegal-opcode halt (optional feature)
dbg_state  out  STATE_W  current state encoding

Behaviour:
- Reset: asynchronous, active-low; clock clk. While reset=0 the state is FETCH_0 and every output is 0. Release is synchronous to the next clk edge.
- Moore machine: outputs decode from state only. Unlisted outputs are 0 and selects are 00; X is never driven.
- FETCH_0: MAR_LOAD, TO=00, FROM=01.
- FETCH_1: PC_INC.
- FETCH_2: IR_LOAD, FROM=10.
- DECODE: no strobes. The next state is chosen from IR; the branch condition is evaluated here from CCR.
- LDA_IMM 0x10 / LDB_IMM 0x12: IMM_0 MAR_LOAD(TO=00, FROM=01); IMM_1 PC_INC; IMM_2 A_LOAD or B_LOAD, FROM=10, instr_done.
- LDA_DIR 0x11 / LDB_DIR 0x13: DIR_0 MAR_LOAD(PC); DIR_1 PC_INC; DIR_2 MAR_LOAD, FROM=10; DIR_3 wait; DIR_4 A/B_LOAD, FROM=10, instr_done.
- STA_DIR 0x14 / STB_DIR 0x15: ST_0 MAR_LOAD(PC); ST_1 PC_INC; ST_2 MAR_LOAD, FROM=10; ST_3 write=1, TO=01 (A) or 10 (B), instr_done.
- ALU 0x20..0x27, one execute state: ALU_SEL=IR[2:0], zero-extended, FROM=00, CCR_LOAD=1, instr_done. B_LOAD for INCB 0x25 / DECB 0x27; A_LOAD for all others.
- Branches 0x30..0x38: BRA always taken. BNU N=1, BND N=0, BZU Z=1, BZD Z=0, BVU V=1, BVD V=0, BCU C=1, BCD C=0.
- Branch taken: BR_0 MAR_LOAD(PC); BR_1 wait; BR_2 PC_LOAD, FROM=10, instr_done.
- Branch not taken: BR_SKIP with PC_INC, instr_done (skips the operand).
- After every final execute state, next state is FETCH_0.
- Cycle totals including fetch+decode: IMM 7, DIR load 9, store 8, ALU 5, branch taken 7, not taken 5.
- CCR is sampled only in DECODE; a CCR change afterwards does not affect the branch in flight.
- Illegal opcode, anything not listed (opcode compare uses the full OPCODE_W): returns from DECODE to FETCH_0 with no strobes.
- Reset asserted mid-instruction: immediate return to FETCH_0 with outputs 0; no partial write is completed.
- Unused state encodings: recover to FETCH_0 on the next clock.

Optional Feature:
CPU_ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE enters HALT. In HALT all strobes are 0 and halt=1. HALT is left only by reset.
- Undefined: illegal opcodes return to FETCH_0 and halt is tied to 0.

Test Plan:
- Reset low 3 cycles, then release, IR=0x10 → outputs all 0 during reset. Then MAR_LOAD, PC_INC, IR_LOAD, decode, MAR_LOAD, PC_INC, A_LOAD+FROM=10. instr_done in cycle 7, back to FETCH_0.
- IR=0x15 → write=1 with TO=10 only in cycle 8. Exactly two MAR_LOAD pulses after fetch (cycles 5, 7), with FROM=01 then 10.
- IR=0x25, then 0x21 → first: ALU_SEL=101, B_LOAD, CCR_LOAD in cycle 5. Second: ALU_SEL=001, A_LOAD. Each instruction takes 5 cycles.
- IR=0x33 with CCR=4'b0100 → taken: PC_LOAD in cycle 7. Repeat with CCR=4'b0000 → PC_INC in cycle 5, no PC_LOAD. CCR toggled after DECODE does not alter the path.
- IR=0xFF → without CPU_ILLEGAL_TRAP_EN, back to FETCH_0 after cycle 4. With it defined, halt=1 and dbg_state is stable until reset.
- Assert reset during ST_3 of STA_DIR → write drops in the same cycle (asynchronous); after release, FETCH_0.
